// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time from execute, checks alignment,
// runs a single data-bus cycle with byte-lane enables and formats the load result.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  // request from execute
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // completion
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall,
  // data bus
  output logic                  bus_en,
  output logic                  bus_we,
  output logic [3:0]            bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e state_q, state_d;

  // Captured op and byte offset, needed to format the load data when the ack arrives
  logic [2:0] op_q;
  logic [1:0] lo_q;

  logic                  req_is_byte, req_is_half, req_is_store, req_misaligned;
  logic [3:0]            req_sel;
  logic [DATA_WIDTH-1:0] req_wfmt;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  accept;

  assign req_ready = (state_q == StIdle);
  assign stall     = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign accept    = req_valid && req_ready;

  // Decode the incoming request: access size, alignment, lane enables, store data
  always_comb begin
    req_is_byte  = 1'b0;
    req_is_half  = 1'b0;
    req_is_store = (req_op > 3'd4);
    case (req_op)
      3'd0, 3'd1, 3'd5: req_is_byte = 1'b1;
      3'd2, 3'd3, 3'd6: req_is_half = 1'b1;
      default: begin end
    endcase
    req_misaligned = (req_is_half && req_addr[0]) ||
                     (!req_is_byte && !req_is_half && (req_addr[1:0] != 2'b00));
    if (req_is_byte) begin
      req_sel  = 4'b0001 << req_addr[1:0];
      req_wfmt = {4{req_wdata[7:0]}};
    end else if (req_is_half) begin
      req_sel  = req_addr[1] ? 4'b1100 : 4'b0011;
      req_wfmt = {2{req_wdata[15:0]}};
    end else begin
      req_sel  = 4'b1111;
      req_wfmt = req_wdata;
    end
  end

  // Extract the addressed lane from the bus word and extend it per the captured op
  always_comb begin
    case (lo_q)
      2'd0:    lane_byte = bus_rdata[7:0];
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
    lane_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_data = {24'b0, lane_byte};
      3'd2:    load_data = {{16{lane_half[15]}}, lane_half};
      3'd3:    load_data = {16'b0, lane_half};
      3'd4:    load_data = bus_rdata;
      default: load_data = '0;  // stores return zero
    endcase
  end

  // Next-state logic; bus_ack only matters while a bus cycle is outstanding
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = req_misaligned ? StResp : StBus;
      StBus:   if (bus_ack) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, registered bus outputs and held response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= 3'd0;
      lo_q      <= 2'd0;
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        lo_q <= req_addr[1:0];
        if (req_misaligned) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          bus_en    <= 1'b1;
          bus_we    <= req_is_store;
          bus_sel   <= req_sel;
          bus_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_wdata <= req_wfmt;
        end
      end
      if ((state_q == StBus) && bus_ack) begin
        bus_en    <= 1'b0;
        rsp_rdata <= load_data;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model compared
// every cycle, plus directed cases with literal expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        bus_en;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int errs = 0;
  int checks = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction arithmetic) ----------------
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd5: return 1;
      3'd2, 3'd3, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] op, input logic [31:0] addr);
    int m;
    m = ((1 << op_size(op)) - 1) << int'(addr[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] store_word(input logic [2:0] op, input logic [31:0] wd);
    case (op_size(op))
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
    int sz;
    int v;
    logic [31:0] sh;
    if (op >= 3'd5) return 32'd0;
    sz = op_size(op);
    if (sz == 4) return rd;
    sh = rd >> (8 * int'(off));
    v = int'(sh & ((32'd1 << (8 * sz)) - 32'd1));
    if ((op == 3'd0 || op == 3'd2) && v >= (1 << (8 * sz - 1))) v = v - (1 << (8 * sz));
    return 32'(v);
  endfunction

  // Phases: 0 waiting for a request, 1 bus transfer outstanding, 2 response cycle
  int          m_phase = 0;
  logic        m_bus_en = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [3:0]  m_sel = 4'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata = 32'd0;
  logic [2:0]  m_op = 3'd0;
  logic [1:0]  m_off = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_bus_en <= 1'b0; m_we <= 1'b0; m_sel <= 4'd0;
      m_addr <= 32'd0; m_wdata <= 32'd0; m_rdata <= 32'd0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_op  <= req_op;
          m_off <= req_addr[1:0];
          if (is_misaligned(req_op, req_addr)) begin
            m_err <= 1'b1; m_rdata <= 32'd0; m_phase <= 2;
          end else begin
            m_bus_en <= 1'b1;
            m_we     <= (req_op >= 3'd5);
            m_sel    <= lanes(req_op, req_addr);
            m_addr   <= req_addr & ~32'h3;
            m_wdata  <= store_word(req_op, req_wdata);
            m_phase  <= 1;
          end
        end
        1: if (bus_ack) begin
          m_bus_en <= 1'b0;
          m_rdata  <= load_value(m_op, m_off, bus_rdata);
          m_err    <= 1'b0;
          m_phase  <= 2;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare every output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
      chk("stall",     32'(stall),     32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
      chk("rsp_rdata", rsp_rdata,      m_rdata);
      chk("bus_en",    32'(bus_en),    32'(m_bus_en));
      chk("bus_we",    32'(bus_we),    32'(m_we));
      chk("bus_sel",   32'(bus_sel),   32'(m_sel));
      chk("bus_addr",  bus_addr,       m_addr);
      chk("bus_wdata", bus_wdata,      m_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (unit must be idle); returns in the cycle after accept
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset stall",     32'(stall),     32'd0);
    chk("reset bus_en",    32'(bus_en),    32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset bus_sel",   32'(bus_sel),   32'd0);
    rst = 1'b0;
    step();

    // LB at 0x1003, two wait cycles
    issue(3'd0, 32'h0000_1003, 32'h0);
    chk("lb bus_en",   32'(bus_en),  32'd1);
    chk("lb bus_sel",  32'(bus_sel), 32'b1000);
    chk("lb bus_addr", bus_addr,     32'h0000_1000);
    step();
    step();
    bus_ack = 1'b1; bus_rdata = 32'h80FF_1234;
    step();
    bus_ack = 1'b0;
    chk("lb rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lb rsp_rdata", rsp_rdata,      32'hFFFF_FF80);
    step();

    // LHU at 0x2002, immediate ack
    issue(3'd3, 32'h0000_2002, 32'h0);
    chk("lhu bus_sel", 32'(bus_sel), 32'b1100);
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    step();
    bus_ack = 1'b0;
    chk("lhu rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lhu rsp_rdata", rsp_rdata,      32'h0000_BEEF);
    step();

    // SB at 0x3001
    issue(3'd5, 32'h0000_3001, 32'h1234_56A5);
    chk("sb bus_we",    32'(bus_we),  32'd1);
    chk("sb bus_sel",   32'(bus_sel), 32'b0010);
    chk("sb bus_wdata", bus_wdata,    32'hA5A5_A5A5);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0;
    chk("sb rsp_rdata", rsp_rdata, 32'h0);
    step();

    // Misaligned LW at 0x4002
    issue(3'd4, 32'h0000_4002, 32'h0);
    chk("lw_mis bus_en",    32'(bus_en),    32'd0);
    chk("lw_mis rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_mis rsp_err",   32'(rsp_err),   32'd1);
    chk("lw_mis rsp_rdata", rsp_rdata,      32'h0);
    step();
    chk("lw_mis ready after", 32'(req_ready), 32'd1);

    // Back-to-back SW then LW with req_valid held
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h0000_5000; req_wdata = 32'hCAFE_F00D;
    step();
    req_op = 3'd4; req_addr = 32'h0000_5004;
    chk("b2b stall bus",   32'(stall),     32'd1);
    chk("b2b ready bus",   32'(req_ready), 32'd0);
    chk("b2b sw wdata",    bus_wdata,      32'hCAFE_F00D);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("b2b stall resp",  32'(stall),     32'd1);
    chk("b2b rsp_valid",   32'(rsp_valid), 32'd1);
    step();
    chk("b2b idle ready",  32'(req_ready), 32'd1);
    chk("b2b idle bus_en", 32'(bus_en),    32'd0);
    step();
    req_valid = 1'b0;
    chk("b2b lw bus_en",   32'(bus_en),  32'd1);
    chk("b2b lw bus_we",   32'(bus_we),  32'd0);
    chk("b2b lw bus_addr", bus_addr,     32'h0000_5004);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    step();
    bus_ack = 1'b0;
    chk("b2b lw rdata",    rsp_rdata,    32'h1122_3344);
    step();

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_addr  = $urandom();
      if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
      req_wdata = $urandom();
      bus_ack   = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom();
      step();
    end

    // Drain to idle
    req_valid = 1'b0;
    bus_ack = 1'b1;
    repeat (3) step();
    bus_ack = 1'b0;
    step();

    // Reset in the middle of a bus cycle, then a late ack
    issue(3'd4, 32'h0000_6000, 32'h0);
    chk("rst_mid bus_en before", 32'(bus_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid bus_en",    32'(bus_en),    32'd0);
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    #2 rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_ack rsp_valid", 32'(rsp_valid), 32'd0);
      chk("late_ack bus_en",    32'(bus_en),    32'd0);
    end
    bus_ack = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
